// File: rtl/rs_age_queue.sv
// Reservation station with age-ordered issue: entries wait on ROB tags,
// capture results from the CDB buses, and the oldest ready entry issues
// into a single registered output slot.
module rs_age_queue #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 6,
  parameter int unsigned NCDB   = 3,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [TAG_W-1:0]         in_rob,
  input  logic [OP_W-1:0]          in_op,
  input  logic [DATA_W-1:0]        in_v1,
  input  logic [DATA_W-1:0]        in_v2,
  input  logic [DATA_W-1:0]        in_imm,
  input  logic [DATA_W-1:0]        in_pc,
  input  logic [TAG_W-1:0]         in_q1,
  input  logic [TAG_W-1:0]         in_q2,
  output logic                     full,
  output logic [CNT_W-1:0]         count,
  input  logic [NCDB-1:0]          cdb_valid,
  input  logic [NCDB*TAG_W-1:0]    cdb_tag,
  input  logic [NCDB*DATA_W-1:0]   cdb_value,
  input  logic                     alu_ready,
  output logic                     out_valid,
  output logic [OP_W-1:0]          out_op,
  output logic [DATA_W-1:0]        out_v1,
  output logic [DATA_W-1:0]        out_v2,
  output logic [DATA_W-1:0]        out_imm,
  output logic [DATA_W-1:0]        out_pc,
  output logic [TAG_W-1:0]         out_rob
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  // Entry storage
  logic [DEPTH-1:0]  r_valid;
  logic [TAG_W-1:0]  r_rob  [DEPTH];
  logic [OP_W-1:0]   r_op   [DEPTH];
  logic [DATA_W-1:0] r_v1   [DEPTH];
  logic [DATA_W-1:0] r_v2   [DEPTH];
  logic [DATA_W-1:0] r_imm  [DEPTH];
  logic [DATA_W-1:0] r_pc   [DEPTH];
  logic [TAG_W-1:0]  r_q1   [DEPTH];
  logic [TAG_W-1:0]  r_q2   [DEPTH];
  // r_older[j][i] set means entry j is older than entry i
  logic [DEPTH-1:0]  r_older [DEPTH];
  logic [CNT_W-1:0]  r_count;

  logic              r_out_valid;
  logic [OP_W-1:0]   r_out_op;
  logic [DATA_W-1:0] r_out_v1, r_out_v2, r_out_imm, r_out_pc;
  logic [TAG_W-1:0]  r_out_rob;

  logic [DEPTH-1:0]  w_ready;
  logic              w_sel_found;
  logic [IDX_W-1:0]  w_sel_idx;
  logic [IDX_W-1:0]  w_free_idx;
  logic [DATA_W:0]   w_lk1 [DEPTH];
  logic [DATA_W:0]   w_lk2 [DEPTH];
  logic [DATA_W:0]   w_in_lk1, w_in_lk2;
  logic              w_slot_free;
  logic              w_insert;
  logic              w_issue;

  // CDB tag lookup: returns {hit, value}; the lowest bus index wins
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [TAG_W-1:0]       tag,
    input logic [NCDB-1:0]        vld,
    input logic [NCDB*TAG_W-1:0]  tags,
    input logic [NCDB*DATA_W-1:0] vals
  );
    logic [DATA_W:0] res;
    res = '0;
    if (tag != '0) begin
      for (int k = int'(NCDB) - 1; k >= 0; k--) begin
        if (vld[k] && (tags[k*TAG_W +: TAG_W] == tag))
          res = {1'b1, vals[k*DATA_W +: DATA_W]};
      end
    end
    return res;
  endfunction

  // Readiness, oldest-ready selection, free slot search and CDB matches
  always_comb begin
    logic blk;
    blk         = 1'b0;
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_free_idx  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_ready[i] = r_valid[i] && (r_q1[i] == '0) && (r_q2[i] == '0);
      w_lk1[i]   = cdb_lookup(r_q1[i], cdb_valid, cdb_tag, cdb_value);
      w_lk2[i]   = cdb_lookup(r_q2[i], cdb_valid, cdb_tag, cdb_value);
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      blk = 1'b0;
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (w_ready[j] && r_older[j][i]) blk = 1'b1;
      end
      if (w_ready[i] && !blk) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(i);
      end
    end
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
    end
    w_in_lk1    = cdb_lookup(in_q1, cdb_valid, cdb_tag, cdb_value);
    w_in_lk2    = cdb_lookup(in_q2, cdb_valid, cdb_tag, cdb_value);
    w_slot_free = !r_out_valid || alu_ready;
    w_insert    = rdy && !flush && in_valid && !full &&
                  (in_rob != '0) && (in_op != '0);
    w_issue     = rdy && !flush && w_slot_free && w_sel_found;
  end

  // Entry state, age matrix, occupancy and issue slot
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_op    <= '0;
    end else if (rdy) begin
      if (flush) begin
        r_valid     <= '0;
        r_count     <= '0;
        r_out_valid <= 1'b0;
      end else begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (r_valid[i]) begin
            if (w_lk1[i][DATA_W]) begin
              r_v1[i] <= w_lk1[i][DATA_W-1:0];
              r_q1[i] <= '0;
            end
            if (w_lk2[i][DATA_W]) begin
              r_v2[i] <= w_lk2[i][DATA_W-1:0];
              r_q2[i] <= '0;
            end
          end
        end
        if (w_slot_free) begin
          r_out_valid <= w_sel_found;
          if (w_sel_found) begin
            r_out_op            <= r_op[w_sel_idx];
            r_out_v1            <= r_v1[w_sel_idx];
            r_out_v2            <= r_v2[w_sel_idx];
            r_out_imm           <= r_imm[w_sel_idx];
            r_out_pc            <= r_pc[w_sel_idx];
            r_out_rob           <= r_rob[w_sel_idx];
            r_valid[w_sel_idx]  <= 1'b0;
          end
        end
        if (w_insert) begin
          r_valid[w_free_idx] <= 1'b1;
          r_rob[w_free_idx]   <= in_rob;
          r_op[w_free_idx]    <= in_op;
          r_imm[w_free_idx]   <= in_imm;
          r_pc[w_free_idx]    <= in_pc;
          r_v1[w_free_idx]    <= w_in_lk1[DATA_W] ? w_in_lk1[DATA_W-1:0] : in_v1;
          r_q1[w_free_idx]    <= w_in_lk1[DATA_W] ? '0 : in_q1;
          r_v2[w_free_idx]    <= w_in_lk2[DATA_W] ? w_in_lk2[DATA_W-1:0] : in_v2;
          r_q2[w_free_idx]    <= w_in_lk2[DATA_W] ? '0 : in_q2;
          for (int j = 0; j < int'(DEPTH); j++) r_older[j][w_free_idx] <= 1'b1;
          r_older[w_free_idx] <= '0;
        end
        r_count <= r_count + CNT_W'(w_insert) - CNT_W'(w_issue);
      end
    end
  end

  assign full      = (r_count == CNT_W'(DEPTH));
  assign count     = r_count;
  assign out_valid = r_out_valid;
  assign out_op    = r_out_op;
  assign out_v1    = r_out_v1;
  assign out_v2    = r_out_v2;
  assign out_imm   = r_out_imm;
  assign out_pc    = r_out_pc;
  assign out_rob   = r_out_rob;

endmodule

// File: tb/tb_rs_age_queue.sv
// Directed bench for rs_age_queue with an issue-order scoreboard.
module tb_rs_age_queue;

  logic        clk, rst, rdy, flush, in_valid;
  logic [3:0]  in_rob, in_q1, in_q2;
  logic [5:0]  in_op;
  logic [31:0] in_v1, in_v2, in_imm, in_pc;
  logic        full;
  logic [4:0]  count;
  logic [2:0]  cdb_valid;
  logic [11:0] cdb_tag;
  logic [95:0] cdb_value;
  logic        alu_ready;
  logic        out_valid;
  logic [5:0]  out_op;
  logic [31:0] out_v1, out_v2, out_imm, out_pc;
  logic [3:0]  out_rob;

  typedef struct {
    logic [3:0]  rob;
    logic [5:0]  op;
    logic [31:0] v1, v2, imm, pc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  rs_age_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .in_valid(in_valid),
    .in_rob(in_rob), .in_op(in_op), .in_v1(in_v1), .in_v2(in_v2),
    .in_imm(in_imm), .in_pc(in_pc), .in_q1(in_q1), .in_q2(in_q2),
    .full(full), .count(count), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .alu_ready(alu_ready), .out_valid(out_valid),
    .out_op(out_op), .out_v1(out_v1), .out_v2(out_v2), .out_imm(out_imm),
    .out_pc(out_pc), .out_rob(out_rob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp_v);
    end
  endtask

  function automatic logic [5:0] op_of(input logic [3:0] rob);
    return 6'(rob) + 6'd1;
  endfunction

  // Drive an insert request; imm/pc/op are derived from the rob tag
  task automatic ins(input logic [3:0] rob, input logic [31:0] v1, input logic [31:0] v2,
                     input logic [3:0] q1, input logic [3:0] q2);
    in_valid = 1'b1;
    in_rob   = rob;
    in_op    = op_of(rob);
    in_v1    = v1;
    in_v2    = v2;
    in_q1    = q1;
    in_q2    = q2;
    in_imm   = 32'h100 * 32'(rob);
    in_pc    = 32'h1000 + 32'(rob);
  endtask

  task automatic push(input logic [3:0] rob, input logic [31:0] v1, input logic [31:0] v2);
    exp_t e;
    e.rob = rob;
    e.op  = op_of(rob);
    e.v1  = v1;
    e.v2  = v2;
    e.imm = 32'h100 * 32'(rob);
    e.pc  = 32'h1000 + 32'(rob);
    sb.push_back(e);
  endtask

  task automatic cdb(input int k, input logic [3:0] tag, input logic [31:0] val);
    cdb_valid[k]        = 1'b1;
    cdb_tag[k*4 +: 4]   = tag;
    cdb_value[k*32 +: 32] = val;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    flush     = 1'b0;
    cdb_valid = '0;
  endtask

  // One clock; a newly loaded issue slot is compared against the scoreboard head
  task automatic tick();
    logic take;
    exp_t e;
    take = rdy && !rst && !flush && (!out_valid || alu_ready);
    @(posedge clk);
    #1;
    if (take && out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_issue", 64'(out_valid), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("issue_rob", 64'(out_rob), 64'(e.rob));
        chk("issue_op",  64'(out_op),  64'(e.op));
        chk("issue_v1",  64'(out_v1),  64'(e.v1));
        chk("issue_v2",  64'(out_v2),  64'(e.v2));
        chk("issue_imm", 64'(out_imm), 64'(e.imm));
        chk("issue_pc",  64'(out_pc),  64'(e.pc));
      end
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; alu_ready = 1'b1;
    in_rob = '0; in_op = '0; in_v1 = '0; in_v2 = '0; in_imm = '0; in_pc = '0;
    in_q1 = '0; in_q2 = '0; cdb_tag = '0; cdb_value = '0;
    idle();
    #1;
    tick(); tick();
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_op", 64'(out_op), 64'(0));
    chk("rst_full", 64'(full), 64'(0));
    rst = 1'b0;
    tick();

    // Single ready insert issues on the following edge
    ins(4'd3, 32'd5, 32'd7, 4'd0, 4'd0); push(4'd3, 32'd5, 32'd7);
    tick();
    chk("t1_count_ins", 64'(count), 64'(1));
    idle();
    tick();
    chk("t1_out_valid", 64'(out_valid), 64'(1));
    chk("t1_count_iss", 64'(count), 64'(0));
    tick();
    chk("t1_out_drop", 64'(out_valid), 64'(0));

    // Younger ready entry overtakes an older waiting one; lowest CDB bus wins
    ins(4'd1, 32'd0, 32'd2, 4'd9, 4'd0);
    tick();
    ins(4'd2, 32'h22, 32'h23, 4'd0, 4'd0); push(4'd2, 32'h22, 32'h23);
    tick();
    idle();
    tick();
    chk("t2_count_mid", 64'(count), 64'(1));
    cdb(0, 4'd9, 32'h55); cdb(1, 4'd9, 32'h66); push(4'd1, 32'h55, 32'd2);
    tick();
    idle();
    tick();
    chk("t2_count_end", 64'(count), 64'(0));
    tick();

    // Same-cycle CDB bypass on insert
    ins(4'd4, 32'h11, 32'd0, 4'd0, 4'd4); cdb(2, 4'd4, 32'hAA);
    push(4'd4, 32'h11, 32'hAA);
    tick();
    idle();
    tick();
    chk("t3_count", 64'(count), 64'(0));
    tick();

    // Fill to DEPTH, drop extra insert, then drain in age order
    for (int i = 0; i < 16; i++) begin
      ins(4'((i % 15) + 1), 32'd0, 32'(i), (i == 0) ? 4'd1 : 4'd2, 4'd0);
      tick();
    end
    chk("t4_full", 64'(full), 64'(1));
    chk("t4_count", 64'(count), 64'(16));
    ins(4'd7, 32'd1, 32'd1, 4'd0, 4'd0);
    tick();
    chk("t4_drop_count", 64'(count), 64'(16));
    idle();
    cdb(0, 4'd1, 32'h77); push(4'd1, 32'h77, 32'd0);
    tick();
    chk("t4_full_wake", 64'(full), 64'(1));
    idle();
    tick();
    chk("t4_count_iss", 64'(count), 64'(15));
    chk("t4_full_drop", 64'(full), 64'(0));
    cdb(0, 4'd2, 32'h80);
    for (int i = 1; i < 16; i++) push(4'((i % 15) + 1), 32'h80, 32'(i));
    tick();
    idle();
    repeat (17) tick();
    chk("t4_drained", 64'(count), 64'(0));

    // Stalled issue slot holds the older entry
    alu_ready = 1'b0;
    ins(4'd10, 32'hA0, 32'hA1, 4'd0, 4'd0); push(4'd10, 32'hA0, 32'hA1);
    tick();
    ins(4'd11, 32'hB0, 32'hB1, 4'd0, 4'd0); push(4'd11, 32'hB0, 32'hB1);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hold_rob", 64'(out_rob), 64'(10));
      chk("t5_hold_valid", 64'(out_valid), 64'(1));
      chk("t5_hold_count", 64'(count), 64'(1));
    end
    alu_ready = 1'b1;
    tick();
    tick();
    chk("t5_empty", 64'(out_valid), 64'(0));

    // Flush discards entries, a pending insert and CDB capture
    for (int i = 1; i <= 5; i++) begin
      ins(4'(i), 32'd0, 32'd0, 4'd3, 4'd0);
      tick();
    end
    chk("t6_count_pre", 64'(count), 64'(5));
    ins(4'd6, 32'd1, 32'd1, 4'd0, 4'd0); flush = 1'b1; cdb(0, 4'd3, 32'h99);
    tick();
    idle();
    chk("t6_count_post", 64'(count), 64'(0));
    chk("t6_out_valid", 64'(out_valid), 64'(0));
    cdb(0, 4'd3, 32'h99);
    repeat (3) tick();
    idle();
    repeat (3) tick();
    chk("t6_count_late", 64'(count), 64'(0));

    // rdy low freezes insert, issue and the output slot
    rdy = 1'b0;
    ins(4'd12, 32'hC0, 32'hC1, 4'd0, 4'd0);
    tick();
    chk("t7_frozen_ins", 64'(count), 64'(0));
    rdy = 1'b1; push(4'd12, 32'hC0, 32'hC1);
    tick();
    chk("t7_count", 64'(count), 64'(1));
    idle(); rdy = 1'b0;
    tick();
    chk("t7_frozen_iss", 64'(out_valid), 64'(0));
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    tick();
    chk("t7_frozen_out", 64'(out_valid), 64'(1));
    chk("t7_frozen_rob", 64'(out_rob), 64'(12));
    rdy = 1'b1;
    tick();
    chk("t7_released", 64'(out_valid), 64'(0));

    // Reset mid-operation discards entries and the issue slot
    ins(4'd13, 32'd1, 32'd2, 4'd0, 4'd0);
    tick();
    rst = 1'b1;
    ins(4'd14, 32'd1, 32'd2, 4'd0, 4'd0);
    tick();
    rst = 1'b0;
    idle();
    chk("t8_count", 64'(count), 64'(0));
    chk("t8_out_valid", 64'(out_valid), 64'(0));
    chk("t8_out_op", 64'(out_op), 64'(0));
    repeat (3) tick();

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
